// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Definitions shared by the UART transmitter and receiver: the
//             default oversampling rate, the data width and the transmit
//             state encoding.
//  Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int UART_DATA_W    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_fifo
//  Purpose  : Synchronous byte FIFO feeding the UART transmit serialiser.
//             A push while full is accepted only if a pop happens in the
//             same cycle (the read side frees the slot first).
//  Ports    : clk    in   clock
//             rst    in   synchronous active-high reset (empties the FIFO)
//             push   in   write request, din captured on this edge
//             din    in   WIDTH write data
//             pop    in   read request, dout is the head before this edge
//             dout   out  WIDTH head of queue (combinational)
//             accept out  push is being taken this cycle
//             full   out  occupancy == DEPTH
//             empty  out  occupancy == 0
//             count  out  occupancy, $clog2(DEPTH)+1 bits
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     accept,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pop_ok;

  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);
  assign pop_ok = pop && !empty;
  assign accept = push && (!full || pop_ok);
  assign dout   = mem_q[rd_ptr_q];
  assign count  = count_q;

  // DEPTH is a power of two, so pointer wrap is the natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(accept);
    rd_ptr_d = rd_ptr_q + PW'(pop_ok);
    count_d  = count_q + CW'(accept) - CW'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy alone defines valid entries.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_transmitter.sv
`default_nettype none
// ============================================================================
//  Module   : uart_transmitter
//  Purpose  : 8N1 UART transmitter. Bytes written on TXen are queued in a
//             small FIFO and serialised LSB-first on TX, with bit timing
//             taken from a 16x-baud tick enable.
//  Ports    : sysclk     in   system clock
//             reset      in   synchronous active-high reset
//             clkfa_tick in   oversampling tick enable (one sysclk wide)
//             TXda       in   byte to send
//             TXen       in   write strobe
//             TX         out  serial line, idle high, registered
//             TXbusy     out  frame on the line or bytes queued
//             TXfull     out  FIFO full
//             TXsta      out  pulse at the end of each frame's stop bit(s)
//             TXovf      out  pulse when a write is dropped
//  Revision : 1.0  initial release
// ============================================================================
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic                   sysclk,
  input  logic                   reset,
  input  logic                   clkfa_tick,
  input  logic [UART_DATA_W-1:0] TXda,
  input  logic                   TXen,
  output logic                   TX,
  output logic                   TXbusy,
  output logic                   TXfull,
  output logic                   TXsta,
  output logic                   TXovf
);

  localparam int TCW = $clog2(OVERSAMPLE);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;

  tx_state_t              state_q, state_d;
  logic [TCW-1:0]         tick_cnt_q, tick_cnt_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [UART_DATA_W-1:0] shreg_q, shreg_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;
  logic                   sta_q, sta_d;
  logic                   ovf_q, ovf_d;

  logic                   pop;
  logic                   bit_end;
  logic [UART_DATA_W-1:0] fifo_dout;
  logic                   fifo_accept;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [CW-1:0]          fifo_count;
  logic [CW-1:0]          count_nxt;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_W)
  ) u_fifo (
    .clk    (sysclk),
    .rst    (reset),
    .push   (TXen),
    .din    (TXda),
    .pop    (pop),
    .dout   (fifo_dout),
    .accept (fifo_accept),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign bit_end   = clkfa_tick && (tick_cnt_q == TCW'(OVERSAMPLE - 1));
  // pop is only ever raised when the FIFO is non-empty, so it always takes effect.
  assign count_nxt = fifo_count + CW'(fifo_accept) - CW'(pop);

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_idx_d  = bit_idx_q;
    shreg_d    = shreg_q;
    tx_d       = tx_q;
    sta_d      = 1'b0;
    pop        = 1'b0;

    if (state_q != IDLE && clkfa_tick) begin
      tick_cnt_d = bit_end ? '0 : tick_cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (clkfa_tick && !fifo_empty) begin
          pop        = 1'b1;
          shreg_d    = fifo_dout;
          tick_cnt_d = '0;
          state_d    = START;
          tx_d       = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
          tx_d      = shreg_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            state_d   = STOP;
            bit_idx_d = 3'd0;
            tx_d      = 1'b1;
          end else begin
            // Next bit is shreg_q[1], i.e. bit 0 after the shift.
            shreg_d   = shreg_q >> 1;
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shreg_q[1];
          end
        end
      end
      STOP: begin
        // bit_idx counts stop bits here.
        if (bit_end) begin
          if (bit_idx_q == 3'(STOP_BITS - 1)) begin
            sta_d = 1'b1;
            if (!fifo_empty) begin
              // Back-to-back frame: straight into the next start bit.
              pop     = 1'b1;
              shreg_d = fifo_dout;
              state_d = START;
              tx_d    = 1'b0;
            end else begin
              state_d = IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    busy_d = (state_d != IDLE) || (count_nxt != '0);
    ovf_d  = TXen && !fifo_accept;
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_idx_q  <= '0;
      shreg_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      sta_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shreg_q    <= shreg_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      sta_q      <= sta_d;
      ovf_q      <= ovf_d;
    end
  end

  assign TX     = tx_q;
  assign TXbusy = busy_q;
  assign TXfull = fifo_full;
  assign TXsta  = sta_q;
  assign TXovf  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_transmitter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_transmitter
//  Purpose  : Self-checking bench for uart_transmitter. A frame-level model
//             (byte queue plus a tick count since frame start) predicts the
//             line and status outputs every cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_transmitter;

  localparam int OS    = 16;
  localparam int DEPTH = 4;
  localparam int NSTOP = 1;
  localparam int FRAME = OS * (9 + NSTOP);

  logic       sysclk     = 1'b0;
  logic       reset      = 1'b1;
  logic       clkfa_tick = 1'b0;
  logic       TXen       = 1'b0;
  logic [7:0] TXda       = 8'h00;
  logic       TX, TXbusy, TXfull, TXsta, TXovf;

  int total = 0;
  int bad   = 0;

  uart_transmitter #(
    .OVERSAMPLE (OS),
    .FIFO_DEPTH (DEPTH),
    .STOP_BITS  (NSTOP)
  ) dut (
    .sysclk     (sysclk),
    .reset      (reset),
    .clkfa_tick (clkfa_tick),
    .TXda       (TXda),
    .TXen       (TXen),
    .TX         (TX),
    .TXbusy     (TXbusy),
    .TXfull     (TXfull),
    .TXsta      (TXsta),
    .TXovf      (TXovf)
  );

  always #5 sysclk = ~sysclk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  // Tick source: 0 off, 1 periodic, 2 random, 3 driven by the main sequence.
  int tick_mode   = 0;
  int tick_period = 4;
  int tick_div    = 0;
  always @(posedge sysclk) begin
    #1;
    case (tick_mode)
      1: begin
        tick_div   = (tick_div + 1) % tick_period;
        clkfa_tick = (tick_div == 0);
      end
      2: clkfa_tick = ($urandom_range(0, 1) == 0);
      3: ;
      default: clkfa_tick = 1'b0;
    endcase
  end

  // Reference model: queue of accepted bytes, and for the frame on the line,
  // the byte and the number of ticks since its start bit began.
  logic [7:0] q[$];
  bit         m_active = 1'b0;
  int         m_cnt    = 0;
  logic [7:0] m_byte   = 8'h00;
  logic       p_rst = 1'b1, p_tick = 1'b0, p_en = 1'b0;
  logic [7:0] p_da  = 8'h00;
  int         sta_seen = 0;
  int         ovf_seen = 0;

  function automatic logic line_bit(input int cnt, input logic [7:0] b);
    int k;
    k = cnt / OS;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  always @(negedge sysclk) begin
    logic e_sta, e_ovf, e_tx;
    bit   was_idle;
    e_sta = 1'b0;
    e_ovf = 1'b0;
    if (p_rst) begin
      q.delete();
      m_active = 1'b0;
      m_cnt    = 0;
    end else begin
      was_idle = !m_active;
      if (m_active && p_tick) begin
        m_cnt++;
        if (m_cnt == FRAME) begin
          e_sta    = 1'b1;
          m_active = 1'b0;
          if (q.size() > 0) begin
            m_byte   = q.pop_front();
            m_active = 1'b1;
            m_cnt    = 0;
          end
        end
      end
      if (was_idle && p_tick && q.size() > 0) begin
        m_byte   = q.pop_front();
        m_active = 1'b1;
        m_cnt    = 0;
      end
      if (p_en) begin
        if (q.size() < DEPTH) q.push_back(p_da);
        else e_ovf = 1'b1;
      end
    end
    e_tx = m_active ? line_bit(m_cnt, m_byte) : 1'b1;
    check_eq("TX", 32'(TX), 32'(e_tx));
    check_eq("TXbusy", 32'(TXbusy), 32'(m_active || q.size() > 0));
    check_eq("TXfull", 32'(TXfull), 32'(q.size() == DEPTH));
    check_eq("TXsta", 32'(TXsta), 32'(e_sta));
    check_eq("TXovf", 32'(TXovf), 32'(e_ovf));
    if (TXsta === 1'b1) sta_seen++;
    if (TXovf === 1'b1) ovf_seen++;
    p_rst  = reset;
    p_tick = clkfa_tick;
    p_en   = TXen;
    p_da   = TXda;
  end

  task automatic step(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    TXen = 1'b1;
    TXda = b;
    step(1);
    TXen = 1'b0;
    TXda = 8'($urandom);
  endtask

  task automatic wait_drain(input string tag, input int limit);
    bit done;
    done = 1'b0;
    for (int i = 0; i < limit; i++) begin
      step(1);
      if (!m_active && q.size() == 0 && !p_en) begin
        done = 1'b1;
        break;
      end
    end
    step(2);
    check_eq(tag, 32'(done), 32'd1);
  endtask

  initial begin
    int s0, o0;
    // 1. reset
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    step(2);

    // 2. single byte, tick every 4 clocks
    tick_mode = 1;
    s0 = sta_seen;
    push(8'hA5);
    wait_drain("drain_a5", 4000);
    check_eq("sta_count_a5", 32'(sta_seen - s0), 32'd1);

    // 3. three back-to-back frames
    s0 = sta_seen;
    push(8'h00);
    push(8'hFF);
    push(8'h3C);
    wait_drain("drain_3", 10000);
    check_eq("sta_count_3", 32'(sta_seen - s0), 32'd3);

    // 4. overfill before any tick
    tick_mode = 0;
    step(1);
    s0 = sta_seen;
    o0 = ovf_seen;
    for (int i = 0; i < 6; i++) push(8'(8'h10 + i));
    step(1);
    check_eq("ovf_count_fill", 32'(ovf_seen - o0), 32'd2);
    tick_mode = 1;
    wait_drain("drain_fill", 12000);
    check_eq("sta_count_fill", 32'(sta_seen - s0), 32'd4);

    // 5. reset during data bit 3
    s0 = sta_seen;
    push(8'hC3);
    begin
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        if (m_active && (m_cnt / OS) == 4) begin
          hit = 1'b1;
          break;
        end
        step(1);
      end
      check_eq("reach_bit3", 32'(hit), 32'd1);
    end
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(20);
    check_eq("sta_after_abort", 32'(sta_seen - s0), 32'd0);
    push(8'h5A);
    wait_drain("drain_5a", 4000);
    check_eq("sta_count_5a", 32'(sta_seen - s0), 32'd1);

    // 6. push into a full FIFO on the same cycle as a pop
    tick_mode  = 3;
    clkfa_tick = 1'b0;
    step(1);
    s0 = sta_seen;
    o0 = ovf_seen;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    clkfa_tick = 1'b1;
    step(1);
    clkfa_tick = 1'b0;
    push(8'h55);
    clkfa_tick = 1'b1;
    step(FRAME - 1);
    TXen = 1'b1;
    TXda = 8'h66;
    step(1);
    TXen       = 1'b0;
    clkfa_tick = 1'b0;
    step(2);
    check_eq("full_after_swap", 32'(TXfull), 32'd1);
    check_eq("ovf_count_swap", 32'(ovf_seen - o0), 32'd0);
    tick_mode = 1;
    wait_drain("drain_swap", 20000);
    check_eq("sta_count_swap", 32'(sta_seen - s0), 32'd6);

    // 7. random traffic with random ticks
    tick_mode = 2;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        for (int j = 0; j < int'($urandom_range(1, 6)); j++) push(8'($urandom));
      end else begin
        step(1);
      end
    end
    wait_drain("drain_rand", 8000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
